// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one command byte to a PS/2 device: it inhibits the clock, requests to
// send, then shifts out d0..d7, odd parity and stop on falling device clocks,
// and finally samples the device ACK.
// The open-collector lines are driven through active-high pull-low enables.
// The tri-state buffers are built at top level.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   tx_data         command byte, taken when tx_valid && tx_ready
//   tx_valid        send request
//   tx_ready        high only while idle
//   ps2_clk_in      raw PS/2 clock line
//   ps2_data_in     raw PS/2 data line
//   ps2_clk_pull    1 = pull PS/2 clock low
//   ps2_data_pull   1 = pull PS/2 data low
//   busy            high from acceptance until the line-idle wait completes
//   done            one-cycle pulse at the end of every transfer
//   ack_err         with done: NACK or timeout
//   timeout         with done: the abort came from the request-to-ACK timeout
//
// Optional build macro PS2_HOST_TX_RETRY_EN:
//   - a NACK or timeout restarts the frame with the same byte, up to two retries;
//   - done reports only the final outcome.

module ps2_host_tx #(
   parameter int INHIBIT_CYC = 12000,
   parameter int TIMEOUT_CYC = 2000000,
   parameter int FILT_LEN    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_pull,
   output logic       ps2_data_pull,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   // One counter serves both the inhibit phase and the ACK timeout,
   // since those never overlap.
   localparam int MAXC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t        state, state_n;
   logic [7:0]    shreg, shreg_n;
   logic          par, par_n;
   logic [3:0]    bitcnt, bitcnt_n;
   logic          data_pull_q, dpull_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          err_q, err_n;
   logic          tmo_q, tmo_n;
   logic          fail;
`ifdef PS2_HOST_TX_RETRY_EN
   logic [7:0]    byte_q, byte_n;
   logic [1:0]    retry_q, retry_n;
`endif

   // Line filters: the filtered level moves only once every sample agrees.
   logic [FILT_LEN-1:0] clk_sh, data_sh;
   logic                clk_f, data_f, clk_f_q;
   logic                fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sh  <= '1;
         data_sh <= '1;
         clk_f   <= 1'b1;
         data_f  <= 1'b1;
         clk_f_q <= 1'b1;
      end else begin
         clk_sh  <= {clk_sh[FILT_LEN-2:0], ps2_clk_in};
         data_sh <= {data_sh[FILT_LEN-2:0], ps2_data_in};
         if (&clk_sh)
            clk_f <= 1'b1;
         else if (~|clk_sh)
            clk_f <= 1'b0;
         if (&data_sh)
            data_f <= 1'b1;
         else if (~|data_sh)
            data_f <= 1'b0;
         clk_f_q <= clk_f;
      end
   end

   assign fall = clk_f_q & ~clk_f;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         shreg       <= '0;
         par         <= 1'b0;
         bitcnt      <= '0;
         data_pull_q <= 1'b0;
         cnt         <= '0;
         err_q       <= 1'b0;
         tmo_q       <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
         byte_q      <= '0;
         retry_q     <= '0;
`endif
      end else begin
         state       <= state_n;
         shreg       <= shreg_n;
         par         <= par_n;
         bitcnt      <= bitcnt_n;
         data_pull_q <= dpull_n;
         cnt         <= cnt_n;
         err_q       <= err_n;
         tmo_q       <= tmo_n;
`ifdef PS2_HOST_TX_RETRY_EN
         byte_q      <= byte_n;
         retry_q     <= retry_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      par_n    = par;
      bitcnt_n = bitcnt;
      dpull_n  = data_pull_q;
      cnt_n    = cnt;
      err_n    = err_q;
      tmo_n    = tmo_q;
      fail     = 1'b0;
      done     = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      byte_n   = byte_q;
      retry_n  = retry_q;
`endif
      case (state)
         S_IDLE: begin
            dpull_n = 1'b0;
            if (tx_valid) begin
               shreg_n  = tx_data;
               par_n    = ~^tx_data;
               bitcnt_n = '0;
               cnt_n    = '0;
               err_n    = 1'b0;
               tmo_n    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
               byte_n   = tx_data;
               retry_n  = '0;
`endif
               state_n  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt == INH_LAST) begin
               // The start bit goes on the line as the clock is released.
               dpull_n = 1'b1;
               cnt_n   = '0;
               state_n = S_REQ;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_REQ, S_DATA, S_PARITY, S_STOP, S_ACK: begin
            if (cnt == TMO_LAST) begin
               dpull_n = 1'b0;
               err_n   = 1'b1;
               tmo_n   = 1'b1;
               fail    = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
               case (state)
                  S_REQ, S_DATA: begin
                     if (fall) begin
                        if (bitcnt == 4'd8) begin
                           dpull_n = ~par;
                           state_n = S_PARITY;
                        end else begin
                           dpull_n  = ~shreg[0];
                           shreg_n  = shreg >> 1;
                           bitcnt_n = bitcnt + 4'd1;
                           state_n  = S_DATA;
                        end
                     end
                  end
                  S_PARITY: begin
                     if (fall) begin
                        dpull_n = 1'b0;
                        state_n = S_STOP;
                     end
                  end
                  S_STOP: begin
                     if (fall)
                        state_n = S_ACK;
                  end
                  S_ACK: begin
                     // The device holds data low across this clock pulse for ACK.
                     if (clk_f) begin
                        err_n = data_f;
                        tmo_n = 1'b0;
                        if (data_f)
                           fail = 1'b1;
                        else
                           state_n = S_WAIT_IDLE;
                     end
                  end
                  default: ;
               endcase
            end
            if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
               if (retry_q != 2'd2) begin
                  retry_n  = retry_q + 2'd1;
                  shreg_n  = byte_q;
                  bitcnt_n = '0;
                  cnt_n    = '0;
                  dpull_n  = 1'b0;
                  err_n    = 1'b0;
                  tmo_n    = 1'b0;
                  state_n  = S_INHIBIT;
               end else begin
                  state_n = S_WAIT_IDLE;
               end
`else
               state_n = S_WAIT_IDLE;
`endif
            end
         end
         S_WAIT_IDLE: begin
            dpull_n = 1'b0;
            if (clk_f && data_f) begin
               done    = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign tx_ready      = (state == S_IDLE);
   assign busy          = (state != S_IDLE);
   assign ps2_clk_pull  = (state == S_INHIBIT);
   assign ps2_data_pull = data_pull_q;
   assign ack_err       = done & err_q;
   assign timeout       = done & tmo_q;

endmodule
